// File: rtl/lcd_disp_ctrl.sv
// lcd_disp_ctrl: panel timing generator that drains RGB565 words from the
// LCD pixel FIFO during the active region and drives HS/VS/DE/RGB with a
// fixed two-cycle latency from counter position to panel pins.
module lcd_disp_ctrl #(
    parameter int          H_SYNC          = 96,
    parameter int          H_BACK          = 48,
    parameter int          H_ACTIVE        = 640,
    parameter int          H_FRONT         = 16,
    parameter int          V_SYNC          = 2,
    parameter int          V_BACK          = 33,
    parameter int          V_ACTIVE        = 480,
    parameter int          V_FRONT         = 10,
    parameter bit          SYNC_POL        = 1'b0,
    parameter logic [15:0] UNDERFLOW_COLOR = 16'hF800
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [15:0] fifo_rd_data,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    output logic        lcd_hs,
    output logic        lcd_vs,
    output logic        lcd_de,
    output logic [4:0]  lcd_r,
    output logic [5:0]  lcd_g,
    output logic [4:0]  lcd_b,
    output logic        frame_start,
    output logic        underflow,
    input  logic        underflow_clr
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_SYN_END = HW'(H_SYNC);
    localparam logic [HW-1:0] H_ACT_BEG = HW'(H_SYNC + H_BACK);
    localparam logic [HW-1:0] H_ACT_END = HW'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_SYN_END = VW'(V_SYNC);
    localparam logic [VW-1:0] V_ACT_BEG = VW'(V_SYNC + V_BACK);
    localparam logic [VW-1:0] V_ACT_END = VW'(V_SYNC + V_BACK + V_ACTIVE);

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    state_t          state;
    state_t          state_next;
    logic [HW-1:0]   h_cnt;
    logic [VW-1:0]   v_cnt;
    logic            stop_req;

    logic            run;
    logic            act;
    logic            hs_pre;
    logic            vs_pre;
    logic            fs_pre;
    logic            frame_wrap;
    logic            ufl_set;

    logic            act_d1;
    logic            hs_d1;
    logic            vs_d1;
    logic            rd_d1;
    logic            fs_d1;
    logic [15:0]     rgb_word;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state: a stop request only takes effect at the frame wrap
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (enable) state_next = PRIME;
            PRIME:   if (!enable) state_next = IDLE;
                     else if (!fifo_empty) state_next = RUN;
            RUN:     if (frame_wrap && (stop_req || !enable)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode: region flags from the counters, read strobe, underflow event
    always_comb begin
        run        = (state == RUN);
        act        = run && (h_cnt >= H_ACT_BEG) && (h_cnt < H_ACT_END)
                         && (v_cnt >= V_ACT_BEG) && (v_cnt < V_ACT_END);
        hs_pre     = run && (h_cnt < H_SYN_END);
        vs_pre     = run && (v_cnt < V_SYN_END);
        fs_pre     = run && (h_cnt == '0) && (v_cnt == '0);
        frame_wrap = (h_cnt == H_LAST) && (v_cnt == V_LAST);
        fifo_rd_en = act && !fifo_empty;
        ufl_set    = act && fifo_empty;
    end

    // Pixel/line counters: advance only in RUN, otherwise parked at 0
    always_ff @(posedge clk) begin
        if (!rst_n || state != RUN) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // Stop request: remembers a dropped enable until the frame completes
    always_ff @(posedge clk) begin
        if (!rst_n || state_next != RUN) stop_req <= 1'b0;
        else if (!enable)                stop_req <= 1'b1;
    end

    // Stage 1: region flags and read-issued, aligned with FIFO read latency
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            act_d1 <= 1'b0;
            hs_d1  <= 1'b0;
            vs_d1  <= 1'b0;
            rd_d1  <= 1'b0;
            fs_d1  <= 1'b0;
        end else begin
            act_d1 <= act;
            hs_d1  <= hs_pre;
            vs_d1  <= vs_pre;
            rd_d1  <= fifo_rd_en;
            fs_d1  <= fs_pre;
        end
    end

    // Stage 2: panel pins; an active slot with no read shows the underflow colour
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lcd_hs      <= ~SYNC_POL;
            lcd_vs      <= ~SYNC_POL;
            lcd_de      <= 1'b0;
            rgb_word    <= '0;
            frame_start <= 1'b0;
        end else begin
            lcd_hs      <= hs_d1 ? SYNC_POL : ~SYNC_POL;
            lcd_vs      <= vs_d1 ? SYNC_POL : ~SYNC_POL;
            lcd_de      <= act_d1;
            frame_start <= fs_d1;
            if (rd_d1)       rgb_word <= fifo_rd_data;
            else if (act_d1) rgb_word <= UNDERFLOW_COLOR;
            else             rgb_word <= '0;
        end
    end

    // Sticky underflow flag; a new event beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (!rst_n)        underflow <= 1'b0;
        else if (ufl_set)  underflow <= 1'b1;
        else if (underflow_clr) underflow <= 1'b0;
    end

    assign lcd_r = rgb_word[15:11];
    assign lcd_g = rgb_word[10:5];
    assign lcd_b = rgb_word[4:0];

endmodule

// File: tb/tb_lcd_disp_ctrl.sv
// tb_lcd_disp_ctrl: scoreboard bench with a frame-position reference model.
module tb_lcd_disp_ctrl;

    localparam int          HS = 3;
    localparam int          HB = 2;
    localparam int          HA = 8;
    localparam int          HF = 2;
    localparam int          VS = 2;
    localparam int          VB = 2;
    localparam int          VA = 4;
    localparam int          VF = 1;
    localparam bit          SP = 1'b0;
    localparam logic [15:0] UFC = 16'hF800;
    localparam int          HT = HS + HB + HA + HF;
    localparam int          VT = VS + VB + VA + VF;
    localparam int          FT = HT * VT;
    localparam int          DEPTH = 4096;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [15:0] fifo_rd_data;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic        lcd_hs, lcd_vs, lcd_de;
    logic [4:0]  lcd_r;
    logic [5:0]  lcd_g;
    logic [4:0]  lcd_b;
    logic        frame_start;
    logic        underflow;
    logic        underflow_clr;

    logic        src_ready;
    logic        force_empty;

    int errors = 0;
    int checks = 0;

    lcd_disp_ctrl #(
        .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
        .SYNC_POL(SP), .UNDERFLOW_COLOR(UFC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en),
        .lcd_hs(lcd_hs), .lcd_vs(lcd_vs), .lcd_de(lcd_de),
        .lcd_r(lcd_r), .lcd_g(lcd_g), .lcd_b(lcd_b),
        .frame_start(frame_start), .underflow(underflow),
        .underflow_clr(underflow_clr)
    );

    always #5 clk = ~clk;

    // FIFO environment: pixel stream is data_mem[0], data_mem[1], ...
    logic [15:0] data_mem [DEPTH];
    int          rd_idx = 0;

    assign fifo_empty = !src_ready || force_empty;

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_rd_data <= data_mem[rd_idx % DEPTH];
            rd_idx       <= rd_idx + 1;
        end
    end

    // Reference model: frame position p within a running frame
    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic        fs;
        logic [15:0] word;
    } rec_t;

    rec_t q[$];
    bit   m_run   = 0;
    bit   m_prime = 0;
    bit   m_stop  = 0;
    int   p       = 0;
    int   exp_idx = 0;
    bit   ufl_exp = 0;

    always @(negedge clk) begin
        int   h, v;
        bit   act, exp_rd;
        rec_t r, e;
        logic [19:0] got, want;

        h = p % HT;
        v = p / HT;
        act = m_run && h >= HS + HB && h < HS + HB + HA && v >= VS + VB && v < VS + VB + VA;
        exp_rd = act && !fifo_empty;

        checks++;
        if (fifo_rd_en !== exp_rd) begin
            errors++;
            $display("FAIL rd_en t=%0t got=%b want=%b", $time, fifo_rd_en, exp_rd);
        end

        checks++;
        if (underflow !== ufl_exp) begin
            errors++;
            $display("FAIL underflow t=%0t got=%b want=%b", $time, underflow, ufl_exp);
        end

        if (q.size() >= 2) begin
            e = q.pop_front();
            got  = {lcd_hs, lcd_vs, lcd_de, frame_start, lcd_r, lcd_g, lcd_b};
            want = {e.hs ? SP : ~SP, e.vs ? SP : ~SP, e.de, e.fs, e.word};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL panel t=%0t got hs/vs/de/fs=%b%b%b%b rgb=%h want %b%b%b%b rgb=%h",
                         $time, got[19], got[18], got[17], got[16], got[15:0],
                         want[19], want[18], want[17], want[16], want[15:0]);
            end
        end

        r.hs   = m_run && h < HS;
        r.vs   = m_run && v < VS;
        r.de   = act;
        r.fs   = m_run && p == 0;
        r.word = !act ? 16'h0000 : (exp_rd ? data_mem[exp_idx % DEPTH] : UFC);
        if (exp_rd) exp_idx++;

        if (!rst_n) begin
            m_run = 0; m_prime = 0; m_stop = 0; p = 0; ufl_exp = 0;
            q.delete();
            q.push_back('0);
            q.push_back('0);
        end else begin
            q.push_back(r);
            ufl_exp = (act && fifo_empty) || (ufl_exp && !underflow_clr);
            if (m_run) begin
                if (!enable) m_stop = 1;
                if (p == FT - 1) begin
                    p = 0;
                    if (m_stop) begin
                        m_run = 0;
                        m_stop = 0;
                    end
                end else begin
                    p++;
                end
            end else if (m_prime) begin
                if (!enable) m_prime = 0;
                else if (!fifo_empty) begin
                    m_prime = 0;
                    m_run = 1;
                    p = 0;
                end
            end else if (enable) begin
                m_prime = 1;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bit seen;
        data_mem[0] = 16'h0000;
        data_mem[1] = 16'h0001;
        for (int i = 2; i < DEPTH; i++) data_mem[i] = 16'($urandom);

        rst_n = 0; enable = 0; src_ready = 0; force_empty = 0; underflow_clr = 0;
        step(3);
        rst_n = 1;

        // Enable with an empty FIFO: must sit in PRIME with no reads
        enable = 1;
        step(50);
        checks++;
        if (rd_idx != 0) begin
            errors++;
            $display("FAIL prime_reads got=%0d want=0", rd_idx);
        end

        // Clean frames
        src_ready = 1;
        step(3 * FT);

        // Short underflow burst mid-line, then clear
        step(HT * (VS + VB + 1) + HS + HB + 2);
        force_empty = 1;
        step(3);
        force_empty = 0;
        step(4);
        underflow_clr = 1;
        step(1);
        underflow_clr = 0;
        step(FT);

        // One-cycle enable drop mid-frame: frame finishes, then restart
        step(FT / 2);
        enable = 0;
        step(1);
        enable = 1;
        step(2 * FT + 10);

        // Randomised phase
        for (int i = 0; i < 3000; i++) begin
            force_empty   = ($urandom_range(0, 7) == 0);
            underflow_clr = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 299) == 0) enable = !enable;
            step(1);
        end
        force_empty = 0; underflow_clr = 0; enable = 1;
        step(2 * FT);

        // Reset during an active pixel
        seen = 0;
        for (int i = 0; i < 4 * FT && !seen; i++) begin
            if (lcd_de) seen = 1;
            else step(1);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wait_de got=timeout want=de_high");
        end
        rst_n = 0;
        step(1);
        checks++;
        if (lcd_de !== 1'b0 || fifo_rd_en !== 1'b0 || lcd_hs !== ~SP) begin
            errors++;
            $display("FAIL reset_mid got de=%b rd=%b hs=%b want de=0 rd=0 hs=%b",
                     lcd_de, fifo_rd_en, lcd_hs, ~SP);
        end
        rst_n = 1;
        step(2 * FT);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
